// File: rtl/fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the PC, issues one imem request at a time,
// drops stale responses after a redirect and presents the fetched word to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        redirect_d,
   input  logic [31:0] redirect_target_d,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus_4_f,
   output logic        instr_valid_f
);

   // state   | meaning
   // IDLE    | one cycle after reset, no request
   // REQ     | request for pc on the bus, waiting for imem_ready
   // WAIT    | request accepted, waiting for its response
   // DISCARD | accepted request went stale, swallow its response
   // VALID   | buffer holds the instruction at pc, waiting for decode
   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DISCARD,
      S_VALID
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic        w_redir;
   logic [31:0] w_target;

   assign w_redir  = redirect_d & ~stall_f;
   assign w_target = {redirect_target_d[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_buf   <= NOP_INSTR;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_REQ;
            end
            S_REQ: begin
               if (w_redir) r_pc <= w_target;
               // an accepted request whose address was just replaced is already stale
               if (imem_ready) r_state <= w_redir ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (w_redir) begin
                     r_pc    <= w_target;
                     r_state <= S_REQ;
                  end else begin
                     r_buf   <= imem_rdata;
                     r_state <= S_VALID;
                  end
               end else if (w_redir) begin
                  r_pc    <= w_target;
                  r_state <= S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (w_redir) r_pc <= w_target;
               if (imem_rvalid) r_state <= S_REQ;
            end
            S_VALID: begin
               if (w_redir) begin
                  r_pc    <= w_target;
                  r_state <= S_REQ;
               end else if (!stall_f) begin
                  r_pc    <= r_pc + 32'd4;
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_req      = (r_state == S_REQ);
   assign imem_addr     = r_pc;
   assign instr_valid_f = (r_state == S_VALID);
   assign instr_f       = instr_valid_f ? r_buf : NOP_INSTR;
   assign pc_f          = r_pc;
   assign pc_plus_4_f   = r_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed corner cases then randomized traffic, with an
// architectural PC model and a scoreboard of the next instruction decode should see.
module tb_fetch_unit;
   localparam logic [31:0] NOP = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_f, redirect_d;
   logic [31:0] redirect_target_d;
   logic        imem_req, imem_ready, imem_rvalid, instr_valid_f;
   logic [31:0] imem_addr, imem_rdata, instr_f, pc_f, pc_plus_4_f;

   logic        req2, ready2, rvalid2, valid2;
   logic [31:0] addr2, rdata2, instr2, pcf2, pc4_2;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .redirect_d(redirect_d),
      .redirect_target_d(redirect_target_d), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_f(instr_f), .pc_f(pc_f), .pc_plus_4_f(pc_plus_4_f), .instr_valid_f(instr_valid_f));

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut2 (
      .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .redirect_d(redirect_d),
      .redirect_target_d(redirect_target_d), .imem_req(req2), .imem_addr(addr2),
      .imem_ready(ready2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
      .instr_f(instr2), .pc_f(pcf2), .pc_plus_4_f(pc4_2), .instr_valid_f(valid2));

   int tests = 0, fails = 0;
   int cyc = 0, n_presented = 0;
   bit mon_en = 0, rand_mode = 0, dut2_go = 0, dut2_done = 0;
   bit resp_pending = 0, presented = 0;
   int resp_cnt = 0, dir_lat = 0;
   logic [31:0] resp_addr, model_pc, pc_hold, e;
   logic [31:0] exp_q[$];
   logic [31:0] acc_log[$];
   int acc_cyc[$];
   bit redir_m, cons_m;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", nm, act, expv);
      end
   endtask

   // instruction memory contents: word at address a is a + 0x1000
   function automatic logic [31:0] memf(input logic [31:0] a);
      return a + 32'h1000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (resp_pending && resp_cnt == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memf(resp_addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (resp_pending) resp_cnt--;
      end
      if (rand_mode) begin
         imem_ready        = ($urandom_range(0, 3) != 0);
         stall_f           = ($urandom_range(0, 3) == 0);
         redirect_d        = ($urandom_range(0, 4) == 0);
         redirect_target_d = $urandom_range(0, 4095);
      end
   endtask

   task automatic model_reset();
      resp_pending = 0;
      presented    = 0;
      model_pc     = 32'h0;
      exp_q.delete();
      exp_q.push_back(32'h0);
   endtask

   // monitor: inputs and outputs are stable at negedge; apply the next posedge's effects to the model
   always @(negedge clk) begin
      cyc++;
      if (mon_en && rst_n) begin
         check("pc_f", pc_f, model_pc);
         check("pc_plus_4_f", pc_plus_4_f, model_pc + 32'd4);
         if (imem_req) check("imem_addr", imem_addr, model_pc);
         if (!instr_valid_f) check("instr_f_nop", instr_f, NOP);
         else if (!presented) begin
            presented = 1;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL scoreboard_empty: got instr %08h expected no instruction", instr_f);
            end else begin
               e = exp_q.pop_front();
               check("sb_instr", instr_f, memf(e));
               check("sb_pc", pc_f, e);
               n_presented++;
            end
         end else check("instr_hold", instr_f, memf(model_pc));
         if (imem_rvalid) resp_pending = 0;
         if (imem_req && imem_ready) begin
            tests++;
            if (resp_pending) begin
               fails++;
               $display("FAIL one_outstanding: got 2 outstanding requests expected at most 1");
            end
            acc_log.push_back(imem_addr);
            acc_cyc.push_back(cyc);
            resp_pending = 1;
            resp_addr    = imem_addr;
            resp_cnt     = rand_mode ? int'($urandom_range(0, 3)) : dir_lat;
         end
         redir_m = redirect_d & ~stall_f;
         cons_m  = instr_valid_f & ~stall_f & ~redir_m;
         if (redir_m || cons_m) begin
            model_pc  = redir_m ? {redirect_target_d[31:2], 2'b00} : model_pc + 32'd4;
            presented = 0;
            exp_q.delete();
            exp_q.push_back(model_pc);
         end
      end
   end

   // second instance: RESET_PC at the top of the address space must wrap to 0
   initial begin
      wait (dut2_go);
      for (int i = 0; i < 10 && !req2; i++) begin
         @(posedge clk);
         #1;
      end
      check("dut2_first_addr", addr2, 32'hFFFF_FFFC);
      @(posedge clk);
      #1;
      rvalid2 = 1'b1;
      rdata2  = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      rvalid2 = 1'b0;
      check("dut2_valid", {31'b0, valid2}, 32'd1);
      check("dut2_instr", instr2, 32'hCAFE_F00D);
      check("dut2_pc4_wrap", pc4_2, 32'h0);
      @(posedge clk);
      #1;
      check("dut2_req_after", {31'b0, req2}, 32'd1);
      check("dut2_addr_wrap", addr2, 32'h0);
      dut2_done = 1;
   end

   int n_acc;
   bit seen_valid;

   initial begin
      rst_n = 1'b0; stall_f = 1'b0; redirect_d = 1'b0; redirect_target_d = 32'h0;
      imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      ready2 = 1'b1; rvalid2 = 1'b0; rdata2 = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'b0, instr_valid_f}, 32'd0);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_instr", instr_f, NOP);
      check("rst_pc", pc_f, 32'h0);
      check("rst_pc4", pc_plus_4_f, 32'h4);
      check("rst_dut2_pc4", pc4_2, 32'h0);
      rst_n = 1'b1; mon_en = 1; dut2_go = 1;

      // 1-cycle memory, no stalls: one fetch per 3 cycles at 0, 4, 8
      repeat (15) step();
      check("acc_count_ge4", {31'b0, acc_log.size() >= 4}, 32'd1);
      if (acc_log.size() >= 4) begin
         check("acc0", acc_log[0], 32'h0);
         check("acc1", acc_log[1], 32'h4);
         check("acc2", acc_log[2], 32'h8);
         check("throughput", acc_cyc[3] - acc_cyc[0], 32'd9);
      end

      // stall in VALID with a redirect pending: frozen, redirect ignored
      for (int i = 0; i < 20 && !instr_valid_f; i++) step();
      check("wait_valid", {31'b0, instr_valid_f}, 32'd1);
      pc_hold = model_pc;
      stall_f = 1'b1; redirect_d = 1'b1; redirect_target_d = 32'h40;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_valid", {31'b0, instr_valid_f}, 32'd1);
         check("stall_pc", pc_f, pc_hold);
      end
      stall_f = 1'b0; redirect_d = 1'b0;
      for (int i = 0; i < 20 && !imem_req; i++) step();
      check("stall_next_addr", imem_addr, pc_hold + 32'd4);

      // redirect while the request is held off by imem_ready=0
      imem_ready = 1'b0;
      n_acc = acc_log.size();
      step(); step();
      redirect_d = 1'b1; redirect_target_d = 32'h83;
      step();
      redirect_d = 1'b0;
      check("req_held", {31'b0, imem_req}, 32'd1);
      check("req_readdr", imem_addr, 32'h80);
      step(); step();
      check("no_accept_while_busy", acc_log.size(), n_acc);
      imem_ready = 1'b1; dir_lat = 3;
      step();
      check("accepted_once", acc_log.size(), n_acc + 1);
      check("accepted_addr", acc_log[$], 32'h80);

      // redirect during WAIT: stale response dropped, refetch from aligned target
      redirect_d = 1'b1; redirect_target_d = 32'h103;
      step();
      redirect_d = 1'b0;
      seen_valid = 0;
      for (int i = 0; i < 20 && !imem_req; i++) begin
         step();
         if (instr_valid_f) seen_valid = 1;
      end
      check("stale_dropped", {31'b0, seen_valid}, 32'd0);
      check("redir_addr", imem_addr, 32'h100);

      // reset asserted while in WAIT
      step();
      check("in_wait", {30'b0, imem_req, instr_valid_f}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, instr_valid_f}, 32'd0);
      check("mid_rst_req", {31'b0, imem_req}, 32'd0);
      check("mid_rst_pc", pc_f, 32'h0);
      model_reset();
      dir_lat = 0;
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 10 && !imem_req; i++) step();
      check("post_rst_addr", imem_addr, 32'h0);

      rand_mode = 1;
      repeat (3000) step();
      rand_mode = 0;
      stall_f = 1'b0; redirect_d = 1'b0; imem_ready = 1'b1;
      repeat (20) step();
      check("enough_presented", {31'b0, n_presented >= 100}, 32'd1);
      check("dut2_done", {31'b0, dut2_done}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS32 pipeline.
- Owns the PC register, drives a variable-latency instruction-memory request/response interface, and applies redirects coming back from decode.
- Presents instr_f / pc_f / pc_plus_4_f to the fetch-to-decode pipeline register.
- Reports instr_valid_f so the hazard unit can stall or bubble the F/D register while fetch is waiting on memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0000, value driven on instr_f whenever instr_valid_f=0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_f  in  1  from hazard unit; 1 = do not consume the F instruction and ignore redirect_d.
- redirect_d  in  1  decode-stage taken branch or jump.
- redirect_target_d  in  32  new PC for a redirect; bits [1:0] ignored.
- imem_req  out  1  request valid (combinational from state).
- imem_addr  out  32  request word address, equal to pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  response instruction word.
- instr_f  out  32  fetched instruction, or NOP_INSTR when not valid.
- pc_f  out  32  PC of instr_f.
- pc_plus_4_f  out  32  pc_f + 4, modulo 2^32 (wraps FFFF_FFFC -> 0000_0000).
- instr_valid_f  out  1  instr_f holds a real instruction.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state=IDLE, pc=RESET_PC, instruction buffer=NOP_INSTR, imem_req=0, instr_valid_f=0, instr_f=NOP_INSTR, pc_f=RESET_PC, pc_plus_4_f=RESET_PC+4.
- Reset asserted mid-operation: return to IDLE immediately; any later response from an old request is not expected.
- redir = redirect_d & ~stall_f.
- Every PC load forces bits [1:0] to 0: pc <= {redirect_target_d[31:2], 2'b00}.
- At most one memory request is outstanding at any time.
- States:
  - IDLE: imem_req=0. Go to REQ unconditionally on the next cycle.
  - REQ: imem_req=1, imem_addr=pc.
    - imem_ready & ~redir -> WAIT.
    - imem_ready & redir -> pc<=target, DISCARD (the accepted request is now stale).
    - ~imem_ready & redir -> pc<=target, stay in REQ; the address may change before acceptance.
  - WAIT: imem_req=0.
    - imem_rvalid & ~redir -> buffer<=imem_rdata, VALID.
    - imem_rvalid & redir -> drop the data, pc<=target, REQ.
    - ~imem_rvalid & redir -> pc<=target, DISCARD.
  - DISCARD: imem_req=0; waits for the stale response.
    - imem_rvalid -> drop the data, REQ; if redir in the same cycle, pc<=target as well.
    - ~imem_rvalid & redir -> pc<=target, stay in DISCARD.
  - VALID: instr_valid_f=1, instr_f=buffer.
    - ~stall_f & ~redir -> pc<=pc+4, REQ (instruction consumed by F/D).
    - redir -> pc<=target, REQ (F instruction killed; the hazard unit clears F/D).
    - stall_f -> hold state, pc and buffer unchanged, outputs stable; redirect_d is ignored.
- pc_f=pc and pc_plus_4_f=pc+4 in all states.
- instr_valid_f=1 only in VALID.
- imem_rvalid outside WAIT/DISCARD is a protocol error: ignore it.
- Throughput: 1-cycle memory and no stalls give one instruction every 3 cycles (REQ, WAIT, VALID).

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1, 1-cycle latency, rdata=addr+32'h1000 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid_f pulses once every 3 cycles with instr_f=0x1000, 0x1004, 0x1008; pc_plus_4_f=0x4, 0x8, 0xC.
- In VALID at pc=0x8, hold stall_f=1 for 4 cycles with redirect_d=1, target=0x40 -> outputs frozen (instr_valid_f=1, pc_f=0x8), redirect ignored; after stall drops, next imem_addr=0xC.
- Request at pc=0x10 accepted, redirect_d=1, target=0x103, stall_f=0 during WAIT, response 3 cycles later -> stale data dropped, instr_valid_f stays 0, next imem_addr=0x100.
- imem_ready=0 for 5 cycles at pc=0x20 and redirect to 0x80 in cycle 2 -> imem_req stays 1, imem_addr changes 0x20 -> 0x80, only 0x80 is ever accepted.
- RESET_PC=32'hFFFF_FFFC -> pc_plus_4_f=0x0; after consumption, next imem_addr=0x0.
- rst_n asserted while in WAIT -> instr_valid_f=0, imem_req=0 and pc_f=RESET_PC immediately; first request after release goes to RESET_PC.
